iomem_stream_bridge: RTL
========================

# iomem_stream_bridge

Memory-mapped responder on the PicoSoC iomem peripheral bus that bridges CPU register accesses to a pair of 8-bit valid/ready byte streams. TX bytes written by firmware are buffered in a FIFO and drained onto a stream toward the USB UART input pipeline. Bytes arriving on the RX stream from the USB UART output pipeline are buffered for firmware to read. The block runs entirely in the SoC clock domain; any 48 MHz crossing sits outside it.

## Interface
- ADDR_HI, 8'h05, value of iomem_addr[31:24] that selects this block
- FIFO_LOG2, 4, log2 of each FIFO depth (depth 16); count fields are FIFO_LOG2+1 bits
- clk  input  1  SoC clock
- resetn  input  1  synchronous, active-low reset
- iomem_valid  input  1  request from initiator, held until iomem_ready
- iomem_wstrb  input  4  byte write strobes; 4'b0000 = read
- iomem_addr  input  32  byte address
- iomem_wdata  input  32  write data
- iomem_ready  output  1  one-cycle completion pulse
- iomem_rdata  output  32  read data, valid with iomem_ready, else 0
- tx_data  output  8  byte toward USB UART input
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts when tx_valid && tx_ready
- rx_data  input  8  byte from USB UART output
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  block accepts when rx_valid && rx_ready

## Operation
- Select: iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI. Register offset = iomem_addr[3:2].
- Offset 0 DATA write (wstrb[0]=1): push wdata[7:0] to TX FIFO. If TX FIFO full, ready is withheld until a slot frees (stall, no drop).
- Offset 0 DATA read: pop RX FIFO, rdata = {24'h0, byte}; if RX empty, rdata = 32'hFFFF_FFFF, no pop, no stall.
- Offset 1 STATUS read: [0] rx_nonempty, [1] tx_full, [2] tx_empty, [12:8] rx_count, [20:16] tx_count, others 0.
- Offset 1 STATUS write (wstrb[0]=1): wdata[0]=1 flushes RX FIFO, wdata[1]=1 flushes TX FIFO.
- Offsets 2,3: read 32'h0, writes ignored, ready still pulses.
- Write with wstrb[0]=0 to offset 0/1: completes, no effect.
- TX side: tx_valid = !tx_empty; tx_data = TX head; pop on tx_valid && tx_ready.
- RX side: rx_ready = resetn && !rx_full; push on rx_valid && rx_ready.
- Each FIFO: circular buffer, pointers FIFO_LOG2 bits wrap modulo depth, count FIFO_LOG2+1 bits (0..depth).

## Timing
- Reset (resetn low at clk edge): FIFOs empty, iomem_ready=0, iomem_rdata=0, tx_valid=0, rx_ready=0.
- Access latency: request sampled at edge N, iomem_ready=1 with rdata during cycle N+1, low at N+2 regardless of iomem_valid. Stalled DATA write: ready in the cycle after the edge where TX count < depth.
- Pushed TX byte visible on tx_valid the cycle after the completing edge.
- RX byte accepted at edge N is readable by a request sampled at edge N+1.
- Simultaneous push and pop on one FIFO: count unchanged, both succeed, including when full (TX: stalled write completes if tx pop occurs same edge) and empty (RX read of empty returns FFFF_FFFF even if a byte lands that edge).
- Flush beats same-edge stream push/pop: FIFO count becomes 0, byte accepted that edge is discarded.
- Reset mid-access or mid-stall: request abandoned, no ready pulse, FIFOs cleared.

## Test plan
- Reset then STATUS read -> rdata = 32'h0000_0004, ready exactly one cycle, rx_ready=1, tx_valid=0.
- Write DATA 0x41,0x42,0x43 with tx_ready=1 -> tx_data 0x41,0x42,0x43 in order, one per cycle, tx_valid then drops.
- tx_ready=0, write 17 bytes -> 16 complete, 17th stalls; pulse tx_ready one cycle -> 17th completes next cycle, STATUS tx_count=16, tx_full=1.
- Drive RX bytes 0x10..0x1F then 0x20 -> rx_ready low after 16th, 0x20 held; DATA reads return 0x10..0x1F, then 0x20, then 32'hFFFF_FFFF.
- Read DATA on empty RX while rx_valid pushes 0x55 same edge -> FFFF_FFFF; next read -> 0x0000_0055.
- STATUS write 0x3 with both FIFOs holding 5 bytes and concurrent rx push -> STATUS reads 0x0000_0004, tx_valid=0.

Source files
------------

// File: rtl/iomem_stream_bridge.sv
// iomem_stream_bridge
//   PicoSoC iomem responder that bridges CPU register accesses to a pair of
//   8-bit valid/ready byte streams. Firmware writes to DATA are queued in a
//   TX FIFO and drained toward the USB UART input. Bytes arriving on the RX
//   stream from the USB UART output are queued for firmware to read back.
//
//   Register map (iomem_addr[31:24] == ADDR_HI, offset = iomem_addr[3:2]):
//     0 DATA   W: push wdata[7:0] to TX, stalls while TX is full
//              R: pop RX -> {24'h0, byte}, or 32'hFFFF_FFFF when RX is empty
//     1 STATUS R: [0] rx_nonempty [1] tx_full [2] tx_empty
//                 [12:8] rx_count [20:16] tx_count
//              W: wdata[0] flushes RX, wdata[1] flushes TX
//     2,3      read 0, writes ignored
//
//   Ports:
//     clk, resetn                   SoC clock, synchronous active-low reset
//     iomem_valid/wstrb/addr/wdata  request from initiator
//     iomem_ready/rdata             one-cycle completion pulse with read data
//     tx_data/tx_valid/tx_ready     byte stream out
//     rx_data/rx_valid/rx_ready     byte stream in
module iomem_stream_bridge #(
  parameter logic [7:0]  ADDR_HI   = 8'h05,
  parameter int unsigned FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_CNT = {1'b1, {FIFO_LOG2{1'b0}}};

  // ---------------------------------------------------------------- decode
  logic       sel;
  logic [1:0] off;
  logic       is_read;
  logic       wr_lane0;
  logic       data_wr;
  logic       data_rd;
  logic       stat_wr;
  logic       stat_rd;
  logic       complete;

  // ---------------------------------------------------------------- FIFOs
  logic [7:0]           tx_mem [DEPTH];
  logic [FIFO_LOG2-1:0] tx_wptr, tx_rptr;
  logic [FIFO_LOG2:0]   tx_count;
  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_flush;

  logic [7:0]           rx_mem [DEPTH];
  logic [FIFO_LOG2-1:0] rx_wptr, rx_rptr;
  logic [FIFO_LOG2:0]   rx_count;
  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_flush;

  logic [31:0] status;
  logic [31:0] rdata_next;

  assign sel      = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
  assign off      = iomem_addr[3:2];
  assign is_read  = (iomem_wstrb == 4'b0000);
  assign wr_lane0 = iomem_wstrb[0];
  assign data_wr  = sel && (off == 2'd0) && wr_lane0;
  assign data_rd  = sel && (off == 2'd0) && is_read;
  assign stat_wr  = sel && (off == 2'd1) && wr_lane0;
  assign stat_rd  = sel && (off == 2'd1) && is_read;

  assign tx_full  = (tx_count == DEPTH_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_CNT);
  assign rx_empty = (rx_count == '0);

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rptr];
  assign rx_ready = resetn && !rx_full;

  assign tx_pop   = tx_valid && tx_ready;
  // A full FIFO still accepts the write when the head leaves on the same edge.
  assign tx_push  = data_wr && (!tx_full || tx_pop);
  assign tx_flush = stat_wr && iomem_wdata[1];

  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = data_rd && !rx_empty;
  assign rx_flush = stat_wr && iomem_wdata[0];

  // Every selected access completes immediately except a DATA write that
  // cannot get a TX slot this edge.
  assign complete = sel && !(data_wr && !tx_push);

  always_comb begin
    status = '0;
    status[0] = !rx_empty;
    status[1] = tx_full;
    status[2] = tx_empty;
    status[8  +: FIFO_LOG2+1] = rx_count;
    status[16 +: FIFO_LOG2+1] = tx_count;
  end

  always_comb begin
    rdata_next = '0;
    if (data_rd) begin
      rdata_next = rx_empty ? '1 : {24'h0, rx_mem[rx_rptr]};
    end else if (stat_rd) begin
      rdata_next = status;
    end
  end

  // ---------------------------------------------------------------- bus response
  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= complete;
      iomem_rdata <= complete ? rdata_next : '0;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) begin
      tx_mem[tx_wptr] <= iomem_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  always_ff @(posedge clk) begin
    if (rx_push && !rx_flush) begin
      rx_mem[rx_wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:8]};

endmodule
